vga_scan_timing: RTL and testbench
==================================

# vga_scan_timing

- Generates 640x480@60 VGA raster timing for the old-film pipeline.
- Drives the row/column counters and VGA_VS consumed directly by the downstream RGB processing stage.
- Drives delay-aligned VGA_HS/VGA_VS/VGA_BLANK_N to the DAC, a frame-start strobe and a frame counter.
- Counters advance only on a pixel-clock enable, so the block runs from the system clock.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal porch/sync widths (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10; V_SYNC, 2; V_BP, 33: vertical porch/sync widths (lines)
- PIPE_DLY, 2, pixel-enable stages of delay on sync/blank outputs (legal 0..4)
- Clock and reset (already decided): clk; reset reset_n, synchronous, active-low.
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- pix_en  in  1  pixel-clock enable; counters and delay line advance only when high
- o_col  out  13  horizontal counter 0..H_TOTAL-1 (H_TOTAL = 800)
- o_row  out  13  vertical counter 0..V_TOTAL-1 (V_TOTAL = 525)
- o_active  out  1  high when o_col < H_ACTIVE and o_row < V_ACTIVE; aligned with counters
- o_frame_start  out  1  one-clk pulse on entry to (row 0, col 0)
- o_frame_count  out  16  frames completed
- VGA_HS  out  1  horizontal sync, active-low, delayed PIPE_DLY
- VGA_VS  out  1  vertical sync, active-low, delayed PIPE_DLY
- VGA_BLANK_N  out  1  high in active video, delayed PIPE_DLY
- VGA_SYNC_N  out  1  tied 0

## Operation
- Scan: o_col increments on each pix_en; at H_TOTAL-1 it wraps to 0 and o_row increments; o_row wraps at V_TOTAL-1.
- Sync decode (undelayed):
  - hs_n = 0 for col in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vs_n = 0 for row in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
  - blank_n = o_active.
- Delay line: hs_n, vs_n and blank_n pass through PIPE_DLY registers that shift only on pix_en.
  - PIPE_DLY=0: outputs are the combinational decode of the current counters.
- Frame start: o_frame_start = 1 for the single clk in which pix_en is high, o_row = V_TOTAL-1 and o_col = H_TOTAL-1 (the wrap edge).
  - It is not asserted after reset release.
- Frame count: o_frame_count increments at that same edge and wraps 65535 -> 0.
- All counter arithmetic is unsigned 13-bit; H_TOTAL/V_TOTAL are derived from the parameters at elaboration.

## Timing
- Reset values: o_col=0, o_row=0, o_active=1 (0,0 is active), o_frame_start=0, o_frame_count=0, VGA_HS=1, VGA_VS=1.
- VGA_BLANK_N resets to 0 for PIPE_DLY>0, or follows o_active if PIPE_DLY=0.
- Reset also fills every delay stage with HS=1, VS=1, BLANK_N=0.
- Reset takes priority over pix_en. A mid-frame reset clears all state at the next edge, with no partial-frame count.
- pix_en low: all registers hold, the delay line does not shift, and o_frame_start stays 0.
- Counter latency: counters update on the clk edge where pix_en = 1.
- Sync latency: VGA_HS/VS/BLANK_N reflect the counter value from PIPE_DLY enabled pixels earlier.
- Downstream RGB registers inserted PIPE_DLY deep therefore stay aligned with sync.
- The row and col wraps happen on the same edge; the counters then read (0,0) and o_frame_start pulses that cycle.

## Configuration
- VGA_SCAN_TEST_PATTERN_EN defined: adds outputs pat_R, pat_G, pat_B (8 bits each), combinational from the counters and aligned with o_col/o_row.
  - Active video: eight vertical bars, each H_ACTIVE/8 = 80 px wide. Bar index b = o_col/80 (bits 2..0 = R,G,B select); each selected channel is 8'hFF, otherwise 8'h00.
  - Outside active video: 0.
  - Intended as raw_VGA_* stimulus when no camera is present.
- Undefined: the ports and logic are absent.

## Test plan
- Reset held 3 clks with pix_en=1 -> o_col=0, o_row=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, o_frame_count=0; after release o_col=1 on the first enabled edge.
- pix_en constant 1, PIPE_DLY=0 -> VGA_HS low exactly for o_col 656..751 (96 clks) on every line; VGA_BLANK_N falls at o_col=640.
- Run 420000 enabled clks -> VS low for rows 490..491 (1600 enables); one o_frame_start pulse at the (524,799)->(0,0) edge; o_frame_count=1; at 2x, count=2.
- pix_en toggling 1,0 -> counters advance once per two clks; the frame period is 840000 clks; no output changes on pix_en=0 cycles.
- PIPE_DLY=2 -> VGA_HS falls two enabled pixels after o_col reaches 656; a reset asserted at row 300 -> next-clk o_row=0, o_col=0, o_frame_count unchanged.
- With VGA_SCAN_TEST_PATTERN_EN: o_col=0 -> pat=00/00/00; o_col=80 -> 00/00/FF; o_col=560 -> FF/FF/FF; o_col=700 -> 0.

Source files
------------

// File: rtl/vga_scan_timing_if.sv
// rtl/vga_scan_timing_if.sv - raster timing bundle between the VGA scan generator and its consumers
interface vga_scan_timing_if;
    logic        pix_en;
    logic [12:0] o_col;
    logic [12:0] o_row;
    logic        o_active;
    logic        o_frame_start;
    logic [15:0] o_frame_count;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        VGA_SYNC_N;
`ifdef VGA_SCAN_TEST_PATTERN_EN
    logic [7:0]  pat_R;
    logic [7:0]  pat_G;
    logic [7:0]  pat_B;

    modport master (
        input  pix_en,
        output o_col, o_row, o_active, o_frame_start, o_frame_count,
        output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        output pat_R, pat_G, pat_B
    );
    modport slave (
        output pix_en,
        input  o_col, o_row, o_active, o_frame_start, o_frame_count,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        input  pat_R, pat_G, pat_B
    );
`else
    modport master (
        input  pix_en,
        output o_col, o_row, o_active, o_frame_start, o_frame_count,
        output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
    );
    modport slave (
        output pix_en,
        input  o_col, o_row, o_active, o_frame_start, o_frame_count,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
    );
`endif
endinterface

// File: rtl/vga_scan_timing.sv
// rtl/vga_scan_timing.sv - 640x480@60 raster counters, sync decode and delay line (VGA_SCAN_TEST_PATTERN_EN adds colour bars)
module vga_scan_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_DLY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    vga_scan_timing_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [12:0] H_LAST = 13'(H_TOTAL - 1);
    localparam logic [12:0] V_LAST = 13'(V_TOTAL - 1);
    localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
    localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [12:0] col_q, col_d;
    logic [12:0] row_q, row_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        fstart_q, fstart_d;
    logic        line_end, frame_end;
    logic        active, hs_n, vs_n;

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        fcnt_d    = fcnt_q;
        fstart_d  = 1'b0;
        line_end  = (col_q == H_LAST);
        frame_end = line_end && (row_q == V_LAST);
        if (vga.pix_en) begin
            col_d = line_end ? 13'd0 : col_q + 13'd1;
            if (line_end) begin
                row_d = frame_end ? 13'd0 : row_q + 13'd1;
            end
            if (frame_end) begin
                fcnt_d   = fcnt_q + 16'd1;
                fstart_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col_q    <= 13'd0;
            row_q    <= 13'd0;
            fcnt_q   <= 16'd0;
            fstart_q <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            fcnt_q   <= fcnt_d;
            fstart_q <= fstart_d;
        end
    end

    assign active = (col_q < H_ACT) && (row_q < V_ACT);
    assign hs_n   = !((col_q >= HS_BEG) && (col_q <= HS_END));
    assign vs_n   = !((row_q >= VS_BEG) && (row_q <= VS_END));

    assign vga.o_col         = col_q;
    assign vga.o_row         = row_q;
    assign vga.o_active      = active;
    assign vga.o_frame_start = fstart_q;
    assign vga.o_frame_count = fcnt_q;
    assign vga.VGA_SYNC_N    = 1'b0;

    // Sync/blank trail the counters by PIPE_DLY enabled pixels so RGB stages of equal depth line up
    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign vga.VGA_HS      = hs_n;
            assign vga.VGA_VS      = vs_n;
            assign vga.VGA_BLANK_N = active;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] hs_q, vs_q, bl_q;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    hs_q <= '1;
                    vs_q <= '1;
                    bl_q <= '0;
                end else if (vga.pix_en) begin
                    hs_q <= (hs_q << 1) | PIPE_DLY'(hs_n);
                    vs_q <= (vs_q << 1) | PIPE_DLY'(vs_n);
                    bl_q <= (bl_q << 1) | PIPE_DLY'(active);
                end
            end

            assign vga.VGA_HS      = hs_q[PIPE_DLY-1];
            assign vga.VGA_VS      = vs_q[PIPE_DLY-1];
            assign vga.VGA_BLANK_N = bl_q[PIPE_DLY-1];
        end
    endgenerate

`ifdef VGA_SCAN_TEST_PATTERN_EN
    localparam logic [12:0] BAR_W = 13'(H_ACTIVE / 8);

    logic [2:0] bar_idx;

    // Bar index bits pick R,G,B so the eight bars walk through every primary/secondary colour
    assign bar_idx   = 3'(col_q / BAR_W);
    assign vga.pat_R = (active && bar_idx[2]) ? 8'hFF : 8'h00;
    assign vga.pat_G = (active && bar_idx[1]) ? 8'hFF : 8'h00;
    assign vga.pat_B = (active && bar_idx[0]) ? 8'hFF : 8'h00;
`endif
endmodule

// File: tb/tb_vga_scan_timing.sv
// tb/tb_vga_scan_timing.sv - directed checks of full-size (delayed) and reduced-size (undelayed) scan timing
module tb_vga_scan_timing;
    logic clk;
    logic rst_full_n;
    logic rst_small_n;
    int   n_vec;
    int   n_bad;

    vga_scan_timing_if full_if ();
    vga_scan_timing_if small_if ();

    vga_scan_timing #(.PIPE_DLY(2)) u_full (
        .clk     (clk),
        .reset_n (rst_full_n),
        .vga     (full_if.master)
    );

    // Small raster: H_TOTAL=24 (HS low cols 18..20), V_TOTAL=8 (VS low rows 5..6), frame = 192 enables
    vga_scan_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DLY(0)
    ) u_small (
        .clk     (clk),
        .reset_n (rst_small_n),
        .vga     (small_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic goto_full(input int c, input int r);
        int n = 0;
        while (!(full_if.o_col == 13'(c) && full_if.o_row == 13'(r)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("goto_full_tmo", 32'(n < 2000), 32'd1);
    endtask

    task automatic goto_small(input int c, input int r);
        int n = 0;
        while (!(small_if.o_col == 13'(c) && small_if.o_row == 13'(r)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("goto_small_tmo", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hs_low, vs_low, first_hs, last_hs, first_bl, fs_seen, first_fs, cnt_mid, holds_bad;
        logic [12:0] p_col, p_row;
        logic        p_hs, p_vs, p_bl;
        logic [15:0] p_cnt;
        logic        en;
        n_vec = 0;
        n_bad = 0;
        rst_full_n      = 1'b0;
        rst_small_n     = 1'b0;
        full_if.pix_en  = 1'b1;
        small_if.pix_en = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_col",     32'(full_if.o_col), 32'd0);
        chk("rst_row",     32'(full_if.o_row), 32'd0);
        chk("rst_active",  32'(full_if.o_active), 32'd1);
        chk("rst_hs",      32'(full_if.VGA_HS), 32'd1);
        chk("rst_vs",      32'(full_if.VGA_VS), 32'd1);
        chk("rst_blank",   32'(full_if.VGA_BLANK_N), 32'd0);
        chk("rst_fcount",  32'(full_if.o_frame_count), 32'd0);
        chk("rst_fstart",  32'(full_if.o_frame_start), 32'd0);
        chk("sync_n",      32'(full_if.VGA_SYNC_N), 32'd0);
        chk("rst_blank_d0", 32'(small_if.VGA_BLANK_N), 32'd1);
        chk("rst_hs_d0",   32'(small_if.VGA_HS), 32'd1);
`ifdef VGA_SCAN_TEST_PATTERN_EN
        chk("pat_col0", {8'h00, full_if.pat_R, full_if.pat_G, full_if.pat_B}, 32'h000000);
`endif

        rst_full_n = 1'b1;
        @(negedge clk);
        chk("first_col", 32'(full_if.o_col), 32'd1);
        chk("first_row", 32'(full_if.o_row), 32'd0);
        chk("first_fstart", 32'(full_if.o_frame_start), 32'd0);

        // One full line of the delayed DUT: sync/blank edges land two pixels after the decode columns
        n = 0; hs_low = 0; first_hs = -1; last_hs = -1; first_bl = -1; fs_seen = 0;
        while (!(full_if.o_row == 13'd1 && full_if.o_col == 13'd10) && n < 2000) begin
            @(negedge clk);
            n++;
            if (full_if.o_row == 13'd0) begin
                if (!full_if.VGA_HS) begin
                    hs_low++;
                    if (first_hs < 0) first_hs = int'(full_if.o_col);
                    last_hs = int'(full_if.o_col);
                end
                if (!full_if.VGA_BLANK_N && full_if.o_col >= 13'd100 && first_bl < 0)
                    first_bl = int'(full_if.o_col);
            end
            if (full_if.o_frame_start) fs_seen++;
        end
        chk("line_tmo",      32'(n < 2000), 32'd1);
        chk("hs_first_col",  32'(first_hs), 32'd658);
        chk("hs_last_col",   32'(last_hs), 32'd753);
        chk("hs_low_count",  32'(hs_low), 32'd96);
        chk("blank_fall_col", 32'(first_bl), 32'd642);
        chk("line_fstart",   32'(fs_seen), 32'd0);
        chk("line_fcount",   32'(full_if.o_frame_count), 32'd0);
        chk("line_vs",       32'(full_if.VGA_VS), 32'd1);

`ifdef VGA_SCAN_TEST_PATTERN_EN
        goto_full(80, 1);
        chk("pat_col80",  {8'h00, full_if.pat_R, full_if.pat_G, full_if.pat_B}, 32'h0000FF);
        goto_full(560, 1);
        chk("pat_col560", {8'h00, full_if.pat_R, full_if.pat_G, full_if.pat_B}, 32'hFFFFFF);
        goto_full(700, 1);
        chk("pat_col700", {8'h00, full_if.pat_R, full_if.pat_G, full_if.pat_B}, 32'h000000);
`endif

        // Small DUT: mid-frame reset, then two full frames at pix_en=1
        rst_small_n = 1'b1;
        goto_small(5, 3);
        rst_small_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_row",    32'(small_if.o_row), 32'd0);
        chk("mid_rst_col",    32'(small_if.o_col), 32'd0);
        chk("mid_rst_fcount", 32'(small_if.o_frame_count), 32'd0);
        chk("mid_rst_fstart", 32'(small_if.o_frame_start), 32'd0);
        rst_small_n = 1'b1;

        hs_low = 0; vs_low = 0; fs_seen = 0; first_fs = -1; cnt_mid = -1;
        for (int i = 1; i <= 384; i++) begin
            @(negedge clk);
            if (small_if.o_frame_start) begin
                fs_seen++;
                if (first_fs < 0) first_fs = i;
            end
            if (i == 192) cnt_mid = int'(small_if.o_frame_count);
            if (!small_if.VGA_HS) hs_low++;
            if (!small_if.VGA_VS) vs_low++;
        end
        chk("frm_pulses",    32'(fs_seen), 32'd2);
        chk("frm_first",     32'(first_fs), 32'd192);
        chk("frm_cnt_1",     32'(cnt_mid), 32'd1);
        chk("frm_cnt_2",     32'(small_if.o_frame_count), 32'd2);
        chk("frm_hs_low",    32'(hs_low), 32'd48);
        chk("frm_vs_low",    32'(vs_low), 32'd96);
        chk("frm_wrap_pos",  32'({small_if.o_row, small_if.o_col}), 32'd0);

        // Alternating pix_en: one frame takes 384 clks and disabled edges change nothing
        holds_bad = 0; fs_seen = 0; first_fs = -1;
        for (int i = 0; i < 400; i++) begin
            en = (i % 2 == 0);
            small_if.pix_en = en;
            p_col = small_if.o_col; p_row = small_if.o_row; p_cnt = small_if.o_frame_count;
            p_hs = small_if.VGA_HS; p_vs = small_if.VGA_VS; p_bl = small_if.VGA_BLANK_N;
            @(negedge clk);
            if (!en && (p_col != small_if.o_col || p_row != small_if.o_row ||
                        p_cnt != small_if.o_frame_count || p_hs != small_if.VGA_HS ||
                        p_vs != small_if.VGA_VS || p_bl != small_if.VGA_BLANK_N))
                holds_bad++;
            if (small_if.o_frame_start) begin
                fs_seen++;
                if (first_fs < 0) first_fs = i;
            end
        end
        chk("tog_hold",   32'(holds_bad), 32'd0);
        chk("tog_pulses", 32'(fs_seen), 32'd1);
        chk("tog_period", 32'(first_fs), 32'd382);
        chk("tog_fcount", 32'(small_if.o_frame_count), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
